// File: rtl/icache_arbiter_if.sv
// Bus bundle between the two icache requesters, the icache itself and the arbiter.
// master = requesters + memory side, slave = arbiter side.
interface icache_arbiter_if;
    logic        f_req;
    logic [29:0] f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;

    logic        d_req;
    logic [29:0] d_addr;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;

    logic [29:0] mem_addr;
    logic [31:0] mem_inst;

    modport master (
        output f_req, f_addr, d_req, d_addr, mem_inst,
        input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, mem_addr
    );

    modport slave (
        input  f_req, f_addr, d_req, d_addr, mem_inst,
        output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, mem_addr
    );
endinterface

// File: rtl/icache_arbiter.sv
// Shares the single-port icache between fetch (priority) and a data read port,
// with a starvation guard that force-grants the data port after MAX_WAIT denials.
module icache_arbiter #(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    icache_arbiter_if.slave  bus,
    output logic [CNT_W-1:0] d_stall_cnt
);

    localparam int unsigned        WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0]  WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;
    logic              owner_v;
    logic              owner;
    logic              force_d;
    logic              f_gnt_c;
    logic              d_gnt_c;

    // Grants are forced low while reset is held so no read is issued then.
    always_comb begin
        force_d = (wait_cnt >= WAIT_MAX);
        d_gnt_c = 1'b0;
        f_gnt_c = 1'b0;
        if (rst) begin
            d_gnt_c = bus.d_req & (~bus.f_req | force_d);
            f_gnt_c = bus.f_req & ~d_gnt_c;
        end
    end

    always_comb begin
        bus.mem_addr = '0;
        if (rst) begin
            bus.mem_addr = d_gnt_c ? bus.d_addr : bus.f_addr;
        end
    end

    assign bus.f_gnt = f_gnt_c;
    assign bus.d_gnt = d_gnt_c;

    // owner tags the read in flight; the icache answers one cycle after the grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_v <= 1'b0;
            owner   <= 1'b0;
        end else begin
            owner_v <= f_gnt_c | d_gnt_c;
            owner   <= d_gnt_c;
        end
    end

    assign bus.f_rvalid = owner_v & ~owner;
    assign bus.d_rvalid = owner_v & owner;
    assign bus.f_rdata  = bus.mem_inst;
    assign bus.d_rdata  = bus.mem_inst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (d_gnt_c || !bus.d_req) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            d_stall_cnt <= '0;
        end else if (bus.d_req && !d_gnt_c && (d_stall_cnt != '1)) begin
            d_stall_cnt <= d_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_icache_arbiter.sv
// Vector table + response scoreboard for icache_arbiter, with a small icache model.
module tb_icache_arbiter;

    localparam int unsigned STALL_MAX = 15;

    logic       clk;
    logic       rst;
    logic [3:0] d_stall_cnt;

    icache_arbiter_if bus ();

    icache_arbiter #(.MAX_WAIT(4), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .d_stall_cnt (d_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // icache model: address registered on the edge, data read combinationally.
    logic [31:0] mem [64];
    logic [5:0]  mem_q;
    always @(posedge clk) mem_q <= bus.mem_addr[5:0];
    assign bus.mem_inst = mem[mem_q];

    typedef struct {
        bit          rst;
        bit          f_req;
        logic [29:0] f_addr;
        bit          d_req;
        logic [29:0] d_addr;
        bit          fg;
        bit          dg;
        bit          late_rst;
    } vec_t;

    typedef struct {
        bit          v;
        bit          is_d;
        logic [31:0] data;
    } rsp_t;

    vec_t vecs[$];
    rsp_t sb[$];
    int   total;
    int   bad;
    int   exp_stall;

    function automatic void add(bit r, bit fr, int fa, bit dr, int da, bit fg, bit dg, bit lr);
        vec_t v;
        v.rst = r; v.f_req = fr; v.f_addr = 30'(fa);
        v.d_req = dr; v.d_addr = 30'(da);
        v.fg = fg; v.dg = dg; v.late_rst = lr;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        rsp_t        r;
        rsp_t        p;
        logic [29:0] ga;
        rst        = v.rst;
        bus.f_req  = v.f_req;
        bus.f_addr = v.f_addr;
        bus.d_req  = v.d_req;
        bus.d_addr = v.d_addr;
        #1;
        if (sb.size() == 0) r = '{v: 1'b0, is_d: 1'b0, data: 32'h0};
        else r = sb.pop_front();
        chk("f_rvalid", 32'(bus.f_rvalid), 32'(r.v && !r.is_d));
        chk("d_rvalid", 32'(bus.d_rvalid), 32'(r.v && r.is_d));
        if (r.v && !r.is_d) chk("f_rdata", bus.f_rdata, r.data);
        if (r.v && r.is_d)  chk("d_rdata", bus.d_rdata, r.data);
        ga = v.dg ? v.d_addr : v.f_addr;
        chk("f_gnt", 32'(bus.f_gnt), 32'(v.fg));
        chk("d_gnt", 32'(bus.d_gnt), 32'(v.dg));
        chk("mem_addr", 32'(bus.mem_addr), v.rst ? 32'(ga) : 32'h0);
        chk("d_stall_cnt", 32'(d_stall_cnt), 32'(exp_stall));
        if (v.late_rst) rst = 1'b0;
        p.v    = v.rst && !v.late_rst && (v.fg || v.dg);
        p.is_d = v.dg;
        p.data = mem[ga[5:0]];
        sb.push_back(p);
        if (!v.rst || v.late_rst) exp_stall = 0;
        else if (v.d_req && !v.dg && exp_stall != STALL_MAX) exp_stall++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_stall = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0]  = 32'h37050020;
        mem[1]  = 32'hb7050010;
        mem[2]  = 32'h370a0002;
        mem[3]  = 32'h130a3a09;
        mem[5]  = 32'h938a3a09;
        mem[13] = 32'he7800500;

        // reset held with both requests up
        for (int i = 0; i < 3; i++) add(0, 1, 7, 1, 9, 0, 0, 0);
        // fetch only, boot program
        for (int i = 0; i < 4; i++) add(1, 1, i, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        // data only
        add(1, 0, 0, 1, 13, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        // contention: force grant on the 5th cycle
        for (int i = 0; i < 4; i++) add(1, 1, 8 + i, 1, 5, 1, 0, 0);
        add(1, 1, 12, 1, 5, 0, 1, 0);
        add(1, 1, 13, 0, 0, 1, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        // withdraw after two denials restarts the wait count
        add(1, 1, 20, 1, 6, 1, 0, 0);
        add(1, 1, 20, 1, 6, 1, 0, 0);
        add(1, 1, 21, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) add(1, 1, 22, 1, 7, 1, 0, 0);
        add(1, 1, 23, 1, 7, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        // sustained contention drives the stall counter into saturation
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) add(1, 1, 24 + i, 1, 40 + k, 1, 0, 0);
            add(1, 1, 28, 1, 40 + k, 0, 1, 0);
        end
        // idle: address follows fetch side, no response
        add(1, 0, 33, 0, 0, 0, 0, 0);
        add(1, 0, 34, 0, 0, 0, 0, 0);

        rst = 1'b0;
        bus.f_req = 1'b0; bus.f_addr = '0;
        bus.d_req = 1'b0; bus.d_addr = '0;
        @(posedge clk);
        #1;
        foreach (vecs[i]) apply(vecs[i]);

        // reset falls late in the grant cycle: response suppressed, next grant normal
        apply('{rst: 1, f_req: 1, f_addr: 30'd2, d_req: 0, d_addr: 30'd0, fg: 1, dg: 0, late_rst: 1});
        apply('{rst: 0, f_req: 1, f_addr: 30'd3, d_req: 0, d_addr: 30'd0, fg: 0, dg: 0, late_rst: 0});
        apply('{rst: 1, f_req: 1, f_addr: 30'd3, d_req: 0, d_addr: 30'd0, fg: 1, dg: 0, late_rst: 0});
        apply('{rst: 1, f_req: 0, f_addr: 30'd0, d_req: 1, d_addr: 30'd13, fg: 0, dg: 1, late_rst: 0});
        apply('{rst: 1, f_req: 0, f_addr: 30'd0, d_req: 0, d_addr: 30'd0, fg: 0, dg: 0, late_rst: 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
